// File: rtl/board_store.sv
// board_store: playfield store for the COLS x ROWS game board.
// Game logic writes single cells while idle. A lock pulse scans for full rows; any full rows are
// flagged in the flash mask for FLASH_CYCLES cycles, then collapsed one row per cycle, and the
// number of rows removed is reported on lines together with a one-cycle done pulse.
// Flattened vectors use bit index row*COLS+col, row 0 at the top, col 0 at the left.
//
// Ports:
//   clk            system clock
//   clr            synchronous active-high reset
//   wr_en          cell write strobe (idle only)
//   wr_row/wr_col  cell coordinates; out-of-range writes are dropped
//   wr_data        cell value, 1 = occupied
//   lock           piece-locked pulse, starts the clear sequence (idle only)
//   busy           high in every state except idle
//   done           one-cycle pulse at the end of a sequence
//   lines          rows cleared by the last sequence
//   object_matrix  registered cell occupancy
//   flash          registered flash mask
module board_store #(
    parameter int COLS         = 10,
    parameter int ROWS         = 20,
    parameter int FLASH_CYCLES = 12500000
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [4:0]           wr_row,
    input  logic [3:0]           wr_col,
    input  logic                 wr_data,
    input  logic                 lock,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines,
    output logic [ROWS*COLS-1:0] object_matrix,
    output logic [ROWS*COLS-1:0] flash
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [CW-1:0] CntLast = CW'(FLASH_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StScan, StFlash, StShift, StDone} state_t;

    state_t          state;
    logic [ROWS-1:0] mask;
    logic [CW-1:0]   cnt;

    logic            wr_ok;
    logic [IW-1:0]   wr_idx;
    logic [ROWS-1:0] full_rows;
    logic [N-1:0]    flash_fill;
    int              pop;
    int              hi;
    logic [N-1:0]    matrix_down;
    logic [N-1:0]    matrix_shift;
    logic [ROWS-1:0] mask_down;
    logic [ROWS-1:0] mask_shift;

    assign wr_ok  = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign wr_idx = IW'(32'(wr_row) * COLS + 32'(wr_col));

    // Full-row detection and the matching flash pattern / line count.
    always_comb begin
        pop = 0;
        for (int r = 0; r < ROWS; r++) begin
            full_rows[r]                = &object_matrix[r*COLS +: COLS];
            flash_fill[r*COLS +: COLS]  = {COLS{full_rows[r]}};
            pop                         = pop + int'(full_rows[r]);
        end
    end

    // One collapse step: rows at or above the lowest full row (index hi) move down by one row,
    // row 0 refills with zeros; the mask moves the same way so later rows stay tracked.
    always_comb begin
        hi = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (mask[r]) hi = r;
        end
        matrix_down = object_matrix << COLS;
        mask_down   = mask << 1;
        for (int r = 0; r < ROWS; r++) begin
            if (r > hi) begin
                matrix_shift[r*COLS +: COLS] = object_matrix[r*COLS +: COLS];
                mask_shift[r]                = mask[r];
            end else begin
                matrix_shift[r*COLS +: COLS] = matrix_down[r*COLS +: COLS];
                mask_shift[r]                = mask_down[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= StIdle;
            mask          <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines         <= '0;
            object_matrix <= '0;
            flash         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (wr_en && wr_ok) object_matrix[wr_idx] <= wr_data;
                    if (lock) begin
                        state <= StScan;
                        busy  <= 1'b1;
                    end
                end
                StScan: begin
                    if (full_rows == '0) begin
                        lines <= '0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        mask  <= full_rows;
                        lines <= 3'(pop);
                        flash <= flash_fill;
                        cnt   <= '0;
                        state <= StFlash;
                    end
                end
                StFlash: begin
                    if (cnt == CntLast) begin
                        flash <= '0;
                        state <= StShift;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StShift: begin
                    object_matrix <= matrix_shift;
                    mask          <= mask_shift;
                    if (mask_shift == '0) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store with FLASH_CYCLES=8.
module tb_board_store;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int FC   = 8;
    localparam int N    = ROWS * COLS;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_row = '0;
    logic [3:0]   wr_col = '0;
    logic         wr_data = 1'b0;
    logic         lock = 1'b0;
    logic         busy;
    logic         done;
    logic [2:0]   lines;
    logic [N-1:0] object_matrix;
    logic [N-1:0] flash;

    board_store #(
        .COLS(COLS),
        .ROWS(ROWS),
        .FLASH_CYCLES(FC)
    ) dut (
        .clk(clk),
        .clr(clr),
        .wr_en(wr_en),
        .wr_row(wr_row),
        .wr_col(wr_col),
        .wr_data(wr_data),
        .lock(lock),
        .busy(busy),
        .done(done),
        .lines(lines),
        .object_matrix(object_matrix),
        .flash(flash)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] row;
        logic [3:0] col;
        logic       d;
        int         ones;
    } wvec_t;

    typedef struct {
        int           lat;
        logic [2:0]   lines;
        logic [N-1:0] flash_mask;
        logic [N-1:0] final_m;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] bitv(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    function automatic logic [N-1:0] rowv(input int r);
        logic [N-1:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v |= bitv(r * COLS + c);
        return v;
    endfunction

    task automatic write_cell(input int r, input int c, input logic d);
        wr_en   = 1'b1;
        wr_row  = 5'(r);
        wr_col  = 4'(c);
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic fill_row(input int r);
        for (int c = 0; c < COLS; c++) write_cell(r, c, 1'b1);
    endtask

    // Pulses lock, follows the sequence to done and compares against the scoreboard entry.
    task automatic run_lock(input string nm, input exp_t e, input logic [N-1:0] pre);
        exp_t got;
        int   k;
        int   fl;
        int   bad;
        sb.push_back(e);
        lock = 1'b1;
        step();
        lock = 1'b0;
        k = 1; fl = 0; bad = 0;
        while (done !== 1'b1 && k < 200) begin
            if (busy !== 1'b1) bad++;
            if (flash != '0) begin
                fl++;
                if (flash !== e.flash_mask || object_matrix !== pre) bad++;
            end
            step();
            k++;
        end
        got = sb.pop_front();
        chk({nm, "_latency"}, N'(k), N'(got.lat));
        chk({nm, "_lines"}, N'(lines), N'(got.lines));
        chk({nm, "_matrix"}, object_matrix, got.final_m);
        chk({nm, "_flash_cycles"}, N'(fl), N'((got.lines != 0) ? FC : 0));
        chk({nm, "_busy_flash_bad"}, N'(bad), N'(0));
        chk({nm, "_busy_at_done"}, N'(busy), N'(1));
        step();
        chk({nm, "_done_low"}, N'(done), N'(0));
        chk({nm, "_busy_low"}, N'(busy), N'(0));
    endtask

    initial begin
        wvec_t        wtab[5];
        exp_t         e;
        logic [N-1:0] pre;
        int           dcnt;
        int           dfirst;

        wtab[0] = '{row: 5'd0,  col: 4'd0,  d: 1'b1, ones: 1};
        wtab[1] = '{row: 5'd19, col: 4'd9,  d: 1'b1, ones: 2};
        wtab[2] = '{row: 5'd20, col: 4'd0,  d: 1'b1, ones: 2};
        wtab[3] = '{row: 5'd5,  col: 4'd12, d: 1'b1, ones: 2};
        wtab[4] = '{row: 5'd3,  col: 4'd10, d: 1'b1, ones: 2};

        step();
        step();
        clr = 1'b0;
        chk("reset_matrix", object_matrix, '0);
        chk("reset_flash", flash, '0);
        chk("reset_busy", N'(busy), N'(0));
        chk("reset_done", N'(done), N'(0));
        chk("reset_lines", N'(lines), N'(0));

        // Cell writes, including out-of-range rows and columns.
        for (int i = 0; i < 5; i++) begin
            write_cell(int'(wtab[i].row), int'(wtab[i].col), wtab[i].d);
            chk($sformatf("write%0d_ones", i), N'($countones(object_matrix)), N'(wtab[i].ones));
        end
        chk("write_matrix", object_matrix, bitv(0) | bitv(199));
        chk("write_busy", N'(busy), N'(0));

        // No full row.
        pre = bitv(0) | bitv(199);
        e = '{lat: 2, lines: 3'd0, flash_mask: '0, final_m: pre};
        run_lock("empty", e, pre);

        // One full row plus a stray cell above it.
        write_cell(0, 0, 1'b0);
        fill_row(19);
        write_cell(18, 3, 1'b1);
        pre = rowv(19) | bitv(183);
        e = '{lat: 11, lines: 3'd1, flash_mask: rowv(19), final_m: bitv(193)};
        run_lock("one", e, pre);

        // Two non-adjacent full rows.
        fill_row(17);
        fill_row(19);
        write_cell(18, 0, 1'b1);
        write_cell(16, 5, 1'b1);
        pre = rowv(17) | rowv(19) | bitv(180) | bitv(165);
        e = '{lat: 12, lines: 3'd2, flash_mask: rowv(17) | rowv(19), final_m: bitv(190) | bitv(185)};
        run_lock("two", e, pre);

        // Write and lock during FLASH are ignored.
        fill_row(19);
        lock = 1'b1;
        step();
        lock = 1'b0;
        dcnt = 0; dfirst = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 4) begin
                wr_en = 1'b1; wr_row = 5'd0; wr_col = 4'd0; wr_data = 1'b1; lock = 1'b1;
            end else begin
                wr_en = 1'b0; lock = 1'b0;
            end
            if (done === 1'b1) begin
                dcnt++;
                if (dfirst == 0) dfirst = k;
            end
            step();
        end
        wr_en = 1'b0; lock = 1'b0;
        chk("busy_ign_done_count", N'(dcnt), N'(1));
        chk("busy_ign_latency", N'(dfirst), N'(11));
        chk("busy_ign_matrix", object_matrix, bitv(195));

        // Reset mid-FLASH aborts with no done.
        fill_row(10);
        lock = 1'b1;
        step();
        lock = 1'b0;
        step(); step(); step();
        chk("pre_clr_flash", flash, rowv(10));
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_matrix", object_matrix, '0);
        chk("clr_flash", flash, '0);
        chk("clr_busy", N'(busy), N'(0));
        chk("clr_lines", N'(lines), N'(0));
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) dcnt++;
            step();
        end
        chk("clr_no_done", N'(dcnt), N'(0));

        // Write and lock in the same cycle: scan sees the new cell.
        write_cell(8, 2, 1'b1);
        for (int c = 0; c < COLS - 1; c++) write_cell(9, c, 1'b1);
        wr_en = 1'b1; wr_row = 5'd9; wr_col = 4'd9; wr_data = 1'b1;
        pre = rowv(9) | bitv(82);
        e = '{lat: 11, lines: 3'd1, flash_mask: rowv(9), final_m: bitv(92)};
        run_lock("same_cycle", e, pre);
        wr_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
